norm_shift_ctrl: RTL and testbench

- Multi-cycle normalization sequencer for the FPU result path.
- Accepts an unnormalized mantissa and exponent from the add/mul stage over a valid/ready handshake.
- Computes the leading-zero/overflow shift and drives the exponent shifter's control inputs (selection, L_or_R, L_shift_value, E). Captures its Ez_pre result.
- Emits a normalized fraction, exponent and exception flags over a second valid/ready handshake.

---
 rtl/norm_shift_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_norm_shift_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_ctrl.sv
// Normalization sequencer for the FPU result path: drives the external exponent shifter and emits a normalized result.
// Optional build macro NORM_PERF_CNT_EN adds the saturating counters perf_ops and perf_lshift.
module norm_shift_ctrl #(
    parameter logic [7:0] EXP_MAX   = 8'hFF,
    parameter bit         FLUSH_UNF = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        sh_selection,
    output logic [1:0]  sh_L_or_R,
    output logic [4:0]  sh_L_shift_value,
    output logic [7:0]  sh_E,
    input  logic [7:0]  sh_Ez_pre,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_exp,
    output logic [22:0] out_mant,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        busy
`ifdef NORM_PERF_CNT_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_lshift
`endif
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 25;
    localparam int unsigned SHV_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ANALYZE = 2'd1,
        S_CHECK   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]  mant_q, mant_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [SHV_W-1:0]   lz;
    logic [SHV_W-1:0]   shamt;
    logic               handshake;

    // Leading zeros of a nonzero 24-bit hidden+fraction field; highest set bit wins.
    function automatic logic [SHV_W-1:0] lzc24(input logic [23:0] m);
        logic [SHV_W-1:0] n;
        n = SHV_W'(24);
        for (int i = 0; i < 24; i++) begin
            if (m[i]) n = SHV_W'(23 - i);
        end
        return n;
    endfunction

    assign handshake = (state_q == S_DONE) && out_ready;

    // Next-state, datapath update and shifter drive.
    always_comb begin
        state_d          = state_q;
        exp_d            = exp_q;
        mant_d           = mant_q;
        zero_d           = zero_q;
        ovf_d            = ovf_q;
        unf_d            = unf_q;
        sh_selection     = 1'b0;
        sh_L_or_R        = 2'b10;
        sh_L_shift_value = '0;
        sh_E             = exp_q;
        lz               = lzc24(mant_q[23:0]);
        shamt            = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    state_d = S_ANALYZE;
                end
            end
            S_ANALYZE: begin
                state_d = S_CHECK;
                if (mant_q == '0) begin
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (mant_q[24]) begin
                    sh_L_or_R = 2'b01;
                    exp_d     = sh_Ez_pre;
                    mant_d    = mant_q >> 1;
                    if ((exp_q == EXP_MAX - 8'd1) || (exp_q == EXP_MAX)) ovf_d = 1'b1;
                end else if (!mant_q[23]) begin
                    if (FLUSH_UNF && (exp_q <= EXP_W'(lz))) begin
                        unf_d   = 1'b1;
                        zero_d  = 1'b1;
                        exp_d   = '0;
                        mant_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        // Without flushing, stop the shift where the exponent lands on 1.
                        if (exp_q > EXP_W'(lz)) shamt = lz;
                        else if (exp_q == '0)   shamt = '0;
                        else                    shamt = SHV_W'(exp_q - 8'd1);
                        if (shamt != '0) begin
                            sh_selection     = 1'b1;
                            sh_L_shift_value = shamt;
                            exp_d            = sh_Ez_pre;
                            mant_d           = mant_q << shamt;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (ovf_q) begin
                    exp_d  = EXP_MAX;
                    mant_d = '0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            exp_q   <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_exp   = exp_q;
    assign out_mant  = mant_q[22:0];
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

`ifdef NORM_PERF_CNT_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_lshift_q, perf_lshift_d;

    // Saturating event counters.
    always_comb begin
        perf_ops_d    = perf_ops_q;
        perf_lshift_d = perf_lshift_q;
        if (handshake && (perf_ops_q != 16'hFFFF)) perf_ops_d = perf_ops_q + 16'd1;
        if (sh_selection && (perf_lshift_q != 16'hFFFF)) perf_lshift_d = perf_lshift_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perf_ops_q    <= '0;
            perf_lshift_q <= '0;
        end else begin
            perf_ops_q    <= perf_ops_d;
            perf_lshift_q <= perf_lshift_d;
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_lshift = perf_lshift_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl: randomized operands against a behavioural normalization model.
`timescale 1ns/1ps
module tb_norm_shift_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        sh_selection;
    logic [1:0]  sh_L_or_R;
    logic [4:0]  sh_L_shift_value;
    logic [7:0]  sh_E;
    logic [7:0]  sh_Ez_pre;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        out_zero, out_ovf, out_unf, busy;
`ifdef NORM_PERF_CNT_EN
    logic [15:0] perf_ops, perf_lshift;
`endif

    always #5 CLK = ~CLK;

    norm_shift_ctrl dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp), .in_mant(in_mant),
        .sh_selection(sh_selection), .sh_L_or_R(sh_L_or_R),
        .sh_L_shift_value(sh_L_shift_value), .sh_E(sh_E), .sh_Ez_pre(sh_Ez_pre),
        .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_mant(out_mant),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf), .busy(busy)
`ifdef NORM_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_lshift(perf_lshift)
`endif
    );

    // Exponent shifter stub: subtract on selection, +1 on L_or_R=01, else hold.
    always_comb begin
        if (sh_selection)            sh_Ez_pre = sh_E - 8'(sh_L_shift_value);
        else if (sh_L_or_R == 2'b01) sh_Ez_pre = sh_E + 8'd1;
        else                         sh_Ez_pre = sh_E;
    end

    typedef struct {
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        zero, ovf, unf;
        int          lat;
        logic        sel;
        logic [1:0]  lor;
        logic [4:0]  lsv;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference normalization with EXP_MAX = 8'hFF and flushing enabled.
    function automatic res_t model(input logic [7:0] e, input logic [24:0] m);
        res_t r;
        int p, lz;
        logic [24:0] t;
        r.exp = e; r.mant = m[22:0]; r.zero = 0; r.ovf = 0; r.unf = 0;
        r.lat = 2; r.sel = 0; r.lor = 2'b10; r.lsv = 0;
        if (m == 0) begin
            r.exp = 0; r.mant = 0; r.zero = 1; r.lat = 1;
        end else if (m[24]) begin
            r.lor = 2'b01;
            if (int'(e) >= 254) begin
                r.ovf = 1; r.exp = 8'hFF; r.mant = 0;
            end else begin
                r.exp = e + 8'd1; r.mant = m[23:1];
            end
        end else if (!m[23]) begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            lz = 23 - p;
            if (int'(e) > lz) begin
                r.sel = 1; r.lsv = 5'(lz);
                r.exp = 8'(int'(e) - lz);
                t = m << lz;
                r.mant = t[22:0];
            end else begin
                r.exp = 0; r.mant = 0; r.zero = 1; r.unf = 1; r.lat = 1;
            end
        end
        return r;
    endfunction

    int          cyc = 0;
    always @(posedge CLK) cyc++;

    logic        pend = 1'b0;
    logic        seen_v = 1'b0;
    int          acc_edge = 0;
    logic [7:0]  cur_e = '0;
    res_t        cur;
    int          n_done = 0;
    int          ops_rst = 0;
    int          lsh_rst = 0;
    logic [7:0]  last_exp;
    logic [22:0] last_mant;
    logic        last_z, last_o, last_u;

    // Compare process: shifter drive, handshake flags and results every cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            pend = 0; seen_v = 0; ops_rst = 0; lsh_rst = 0;
        end else begin
            chk("ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (pend) chk("busy_pending", 32'(busy), 32'd1);
            if (pend && cyc == acc_edge) begin
                chk("an_sel", 32'(sh_selection), 32'(cur.sel));
                chk("an_lor", 32'(sh_L_or_R), 32'(cur.lor));
                chk("an_lsv", 32'(sh_L_shift_value), 32'(cur.lsv));
                chk("an_E", 32'(sh_E), 32'(cur_e));
                if (cur.sel) lsh_rst++;
            end else begin
                chk("idle_sel", 32'(sh_selection), 32'd0);
                chk("idle_lor", 32'(sh_L_or_R), 32'd2);
                chk("idle_lsv", 32'(sh_L_shift_value), 32'd0);
            end
            if (out_valid) begin
                if (!pend) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen_v) begin
                        chk("latency", 32'(cyc - acc_edge), 32'(cur.lat));
                        seen_v = 1;
                    end
                    chk("out_exp", 32'(out_exp), 32'(cur.exp));
                    chk("out_mant", 32'(out_mant), 32'(cur.mant));
                    chk("out_zero", 32'(out_zero), 32'(cur.zero));
                    chk("out_ovf", 32'(out_ovf), 32'(cur.ovf));
                    chk("out_unf", 32'(out_unf), 32'(cur.unf));
                    if (out_ready) begin
                        last_exp = out_exp; last_mant = out_mant;
                        last_z = out_zero; last_o = out_ovf; last_u = out_unf;
                        pend = 0; seen_v = 0; n_done++; ops_rst++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                cur = model(in_exp, in_mant);
                cur_e = in_exp;
                acc_edge = cyc + 1;
                pend = 1; seen_v = 0;
            end
        end
    end

    task automatic send(input logic [7:0] e, input logic [24:0] m);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin @(posedge CLK); #1; k++; end
        chk("wait_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_exp = e; in_mant = m;
        @(posedge CLK); #1;
        in_valid = 1'b0; in_exp = 8'($urandom); in_mant = 25'($urandom);
    endtask

    task automatic do_op(input logic [7:0] e, input logic [24:0] m, input bit rnd_ready);
        int k, d0;
        d0 = n_done;
        send(e, m);
        k = 0;
        while (n_done == d0 && k < 60) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK); #1; k++;
        end
        out_ready = 1'b0;
        chk("op_timeout", 32'(n_done - d0), 32'd1);
    endtask

    // Directed operands with hand-computed results: {exp, mant, zero, ovf, unf}.
    logic [7:0]  d_e   [9] = '{8'h80, 8'h80, 8'h85, 8'h03, 8'hFE, 8'h00, 8'h10, 8'h0D, 8'hFD};
    logic [24:0] d_m   [9] = '{25'h0800000, 25'h1000001, 25'h0000100, 25'h0000001, 25'h1800000,
                               25'h0000000, 25'h0000400, 25'h0000400, 25'h1000002};
    logic [7:0]  d_xe  [9] = '{8'h80, 8'h81, 8'h76, 8'h00, 8'hFF, 8'h00, 8'h03, 8'h00, 8'hFE};
    logic [22:0] d_xm  [9] = '{23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h000001};
    logic [2:0]  d_xf  [9] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b010, 3'b100, 3'b000, 3'b101, 3'b000};

    initial begin
        logic [24:0] mask;
        int k, w;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_exp", 32'(out_exp), 32'd0);
        chk("rst_flags", 32'({out_zero, out_ovf, out_unf}), 32'd0);
        #22 RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(d_e[i], d_m[i], 1'b0);
            chk("dir_exp", 32'(last_exp), 32'(d_xe[i]));
            chk("dir_mant", 32'(last_mant), 32'(d_xm[i]));
            chk("dir_flags", 32'({last_z, last_o, last_u}), 32'(d_xf[i]));
        end

        for (int i = 0; i < 300; i++) begin
            w = $urandom_range(0, 25);
            mask = '0;
            for (int b = 0; b < w; b++) mask[b] = 1'b1;
            k = $urandom_range(0, 3);
            do_op((k == 0) ? 8'($urandom_range(250, 255)) :
                  (k == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom),
                  25'($urandom) & mask, 1'b1);
        end

        // Stall in DONE on an overflow result, then reset mid-operation.
        send(8'hFE, 25'h1800000);
        k = 0;
        while (!out_valid && k < 10) begin @(posedge CLK); #1; k++; end
        chk("stall_valid", 32'(out_valid), 32'd1);
        repeat (5) @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_exp", 32'(out_exp), 32'd0);
        chk("mid_rst_flags", 32'({out_zero, out_ovf, out_unf}), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst_idle", 32'({out_valid, busy, in_ready}), 32'b001);

        do_op(8'h85, 25'h0000100, 1'b0);
        chk("recover_exp", 32'(last_exp), 32'h76);
`ifdef NORM_PERF_CNT_EN
        chk("perf_ops", 32'(perf_ops), 32'(ops_rst));
        chk("perf_lshift", 32'(perf_lshift), 32'(lsh_rst));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
